controller_nios2e_oci_trace_packer: RTL and testbench

//  Parametrised successor of the OCI debug-trace test bench hook. Packs FRAME_W-bit trace

---
 rtl/controller_nios2e_oci_trace_packer.sv | 136 +++++++++++++
 tb/tb_controller_nios2e_oci_trace_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller_nios2e_oci_trace_packer.sv
// OCI trace packer: shifts trace frames into packed words, queues them in a
// small FIFO and drains them on a valid/ready port, with end-of-test flush.
module controller_nios2e_oci_trace_packer #(
    parameter int FRAME_W    = 2,
    parameter int FRAMES     = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [FRAME_W-1:0]            in_frame,
    output logic                          in_ready,
    input  logic                          test_ending,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FRAMES*FRAME_W-1:0]     out_buffer,
    output logic [CNT_W-1:0]              out_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   stall_cycles,
    output logic                          test_has_ended
);

    localparam int BUF_W = FRAMES * FRAME_W;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BUF_W-1:0] buffer;
    logic [CNT_W-1:0] count;

    logic [BUF_W-1:0] mem_buf [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_cnt [FIFO_DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [LVL_W-1:0] level;

    logic fifo_full;
    logic fifo_empty;
    logic count_full;
    logic accept;
    logic push;
    logic pop;

    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign count_full = (count == CNT_W'(FRAMES));

    assign in_ready = (state == ST_RUN) && reset_n
                    && (!count_full || !fifo_full);
    assign accept   = in_valid && in_ready;

    assign push = !fifo_full
                && (((state == ST_RUN) && count_full)
                 || ((state == ST_FLUSH) && (count != '0)));

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    assign out_buffer     = out_valid ? mem_buf[rptr] : '0;
    assign out_count      = out_valid ? mem_cnt[rptr] : '0;
    assign fifo_level     = level;
    assign test_has_ended = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:   if (test_ending) state_nxt = ST_FLUSH;
            ST_FLUSH: if (count == '0 && fifo_empty) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    // Pushed word takes the pre-edge buffer; vacated slots restart from zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buffer <= '0;
            count  <= '0;
        end else if (accept) begin
            if (push) begin
                buffer <= {{(BUF_W-FRAME_W){1'b0}}, in_frame};
                count  <= CNT_W'(1);
            end else begin
                buffer <= {buffer[BUF_W-FRAME_W-1:0], in_frame};
                count  <= count + CNT_W'(1);
            end
        end else if (push) begin
            buffer <= '0;
            count  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop)      level <= level + LVL_W'(1);
            else if (!push && pop) level <= level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_buf[wptr] <= buffer;
            mem_cnt[wptr] <= count;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if ((state == ST_RUN) && in_valid && !in_ready
                     && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_controller_nios2e_oci_trace_packer.sv
// Bench for the trace packer: queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_controller_nios2e_oci_trace_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_frame = '0;
    logic        in_ready;
    logic        test_ending = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [29:0] out_buffer;
    logic [3:0]  out_count;
    logic [2:0]  fifo_level;
    logic [15:0] stall_cycles;
    logic        test_has_ended;

    controller_nios2e_oci_trace_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_frame       (in_frame),
        .in_ready       (in_ready),
        .test_ending    (test_ending),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_buffer     (out_buffer),
        .out_count      (out_count),
        .fifo_level     (fifo_level),
        .stall_cycles   (stall_cycles),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0=RUN 1=FLUSH 2=DONE; fq = frames in buffer, oldest first;
    // wq = queued words {count, word}.
    int          mst = 0;
    logic [1:0]  fq[$];
    logic [33:0] wq[$];
    int          mstall = 0;
    int          npops = 0;
    int          nacc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] pack_frames();
        logic [63:0] v;
        v = 0;
        foreach (fq[i]) v = v * 4 + 64'(fq[i]);
        return v[29:0];
    endfunction

    function automatic bit m_ready();
        return mst == 0 && reset_n && (fq.size() < 15 || wq.size() < 4);
    endfunction

    task automatic compare_all();
        logic [33:0] h;
        h = (wq.size() > 0) ? wq[0] : 34'd0;
        chk("in_ready", 64'(in_ready), 64'(m_ready()));
        chk("out_valid", 64'(out_valid), 64'(wq.size() > 0));
        chk("out_buffer", 64'(out_buffer), 64'(h[29:0]));
        chk("out_count", 64'(out_count), 64'(h[33:30]));
        chk("fifo_level", 64'(fifo_level), 64'(wq.size()));
        chk("stall_cycles", 64'(stall_cycles), 64'(mstall));
        chk("test_has_ended", 64'(test_has_ended), 64'(mst == 2));
    endtask

    task automatic step(input bit v, input logic [1:0] f, input bit te,
                        input bit ordy);
        bit acc, push, pop, stall, to_flush, to_done;
        in_valid    = v;
        in_frame    = f;
        test_ending = te;
        out_ready   = ordy;
        acc   = v && m_ready();
        push  = wq.size() < 4
              && ((mst == 0 && fq.size() == 15) || (mst == 1 && fq.size() > 0));
        pop   = wq.size() > 0 && ordy;
        stall = mst == 0 && v && !m_ready();
        to_flush = mst == 0 && te;
        to_done  = mst == 1 && fq.size() == 0 && wq.size() == 0;
        @(posedge clk);
        if (!reset_n) begin
            mst = 0;
            fq.delete();
            wq.delete();
            mstall = 0;
        end else begin
            if (pop) begin
                void'(wq.pop_front());
                npops++;
            end
            if (push) begin
                wq.push_back({4'(fq.size()), pack_frames()});
                fq.delete();
            end
            if (acc) begin
                fq.push_back(f);
                nacc++;
            end
            if (stall && mstall < 65535) mstall++;
            if (to_flush) mst = 1;
            else if (to_done) mst = 2;
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(0, 2'd0, 0, 0);
        step(0, 2'd0, 0, 0);
        reset_n = 1'b1;
        npops = 0;
        nacc = 0;
    endtask

    initial begin
        int guard;

        // Reset held for 3 clocks
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_fifo_level", 64'(fifo_level), 64'd0);
        chk("rst_ended", 64'(test_has_ended), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // One full word, frames i%4 for i=1..15
        for (int i = 1; i <= 15; i++) step(1, 2'(i % 4), 0, 1);
        chk("full_not_yet", 64'(out_valid), 64'd0);
        step(0, 2'd0, 0, 1);
        chk("full_valid", 64'(out_valid), 64'd1);
        chk("full_word", 64'(out_buffer), 64'h1B1B1B1B);
        chk("full_count", 64'(out_count), 64'd15);
        step(0, 2'd0, 0, 1);
        chk("full_popped", 64'(out_valid), 64'd0);

        // Backpressure: 75 frames with the sink stalled
        do_reset();
        guard = 0;
        while (nacc < 75 && guard < 200) begin
            step(1, 2'((nacc * 3) % 4), 0, 0);
            guard++;
        end
        chk("bp_accepted", 64'(nacc), 64'd75);
        chk("bp_level", 64'(fifo_level), 64'd4);
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) step(1, 2'd2, 0, 0);
        chk("bp_stalls", 64'(stall_cycles), 64'd3);
        guard = 0;
        while ((wq.size() > 0 || fq.size() > 0) && guard < 40) begin
            step(0, 2'd0, 0, 1);
            guard++;
        end
        chk("bp_words", 64'(npops), 64'd5);

        // Flush of a 7-frame partial word
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 2'd3, 0, 0);
        step(0, 2'd0, 1, 0);
        step(0, 2'd0, 0, 0);
        chk("part_count", 64'(out_count), 64'd7);
        chk("part_word", 64'(out_buffer), 64'h3FFF);
        chk("part_upper", 64'(out_buffer[29:14]), 64'd0);
        step(0, 2'd0, 0, 1);
        chk("part_not_ended", 64'(test_has_ended), 64'd0);
        step(0, 2'd0, 0, 1);
        chk("part_ended", 64'(test_has_ended), 64'd1);

        // test_ending together with the 15th accept
        do_reset();
        for (int i = 0; i < 14; i++) step(1, 2'd2, 0, 1);
        step(1, 2'd1, 1, 1);
        guard = 0;
        while (!test_has_ended && guard < 10) begin
            step(0, 2'd0, 0, 1);
            guard++;
        end
        chk("te15_ended", 64'(test_has_ended), 64'd1);
        chk("te15_one_word", 64'(npops), 64'd1);

        // test_ending with nothing buffered
        do_reset();
        step(0, 2'd0, 1, 0);
        step(0, 2'd0, 0, 0);
        chk("empty_done", 64'(test_has_ended), 64'd1);

        // Reset during flush
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 2'd1, 0, 0);
        step(0, 2'd0, 1, 0);
        step(0, 2'd0, 0, 0);
        chk("mid_level", 64'(fifo_level), 64'd1);
        reset_n = 1'b0;
        step(0, 2'd0, 0, 0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        reset_n = 1'b1;
        step(0, 2'd0, 0, 0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
